// File: rtl/debug_frame_tx_if.sv
// Debug-snapshot transmit bus: send request and snapshot in, UART tx handshake and status out.
interface debug_frame_tx_if #(
    parameter int DATA_W = 2560
);
    logic              is_send;
    logic [DATA_W-1:0] i_data;
    logic              is_tx_done;
    logic [7:0]        o_tx_byte;
    logic              os_tx_start;
    logic              o_busy;
    logic              os_frame_done;

    modport master (
        output is_send, i_data, is_tx_done,
        input  o_tx_byte, os_tx_start, o_busy, os_frame_done
    );

    modport slave (
        input  is_send, i_data, is_tx_done,
        output o_tx_byte, os_tx_start, o_busy, os_frame_done
    );
endinterface

// File: rtl/debug_frame_tx.sv
// Serializes one latched pipeline snapshot LSB-first into bytes using the UART tx start/done handshake.
module debug_frame_tx #(
    parameter int DATA_W = 2560
) (
    input  logic             clk,
    input  logic             rst,
    debug_frame_tx_if.slave  bus
);
    localparam int N_BYTES = DATA_W / 8;
    localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DONE
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shadow;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_tx_byte;
    logic              r_tx_start;
    logic              r_busy;
    logic              r_frame_done;
    logic [DATA_W-1:0] w_next_shadow;

    // The byte currently on the wire always sits in r_shadow[7:0].
    assign w_next_shadow = r_shadow >> 8;

    assign bus.o_tx_byte     = r_tx_byte;
    assign bus.os_tx_start   = r_tx_start;
    assign bus.o_busy        = r_busy;
    assign bus.os_frame_done = r_frame_done;

    // Start and done pulses are registered one cycle early so they line up with START/DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shadow     <= '0;
            r_idx        <= '0;
            r_tx_byte    <= 8'h00;
            r_tx_start   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_tx_start   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.is_send) begin
                        r_shadow   <= bus.i_data;
                        r_idx      <= '0;
                        r_tx_byte  <= bus.i_data[7:0];
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (bus.is_tx_done) begin
                        if (r_idx == LAST_IDX) begin
                            r_frame_done <= 1'b1;
                            r_state      <= DONE;
                        end else begin
                            r_shadow   <= w_next_shadow;
                            r_idx      <= r_idx + 1'b1;
                            r_tx_byte  <= w_next_shadow[7:0];
                            r_tx_start <= 1'b1;
                            r_state    <= START;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
